enc42_seq: RTL and testbench
============================

ENC42_SEQ -- requirements
Module: enc42_seq

Interface
REQ-001 Parameter PRIO_HIGH, default 1, meaning: 1 = bit 3 highest priority; 0 = bit 0 highest priority.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 y  input  4  multi-hot request vector to be encoded (decoder-output format).
REQ-005 e  input  1  enable; gates capture only.
REQ-006 load  input  1  capture strobe, sampled when idle.
REQ-007 a  output  2  encoded index of current request.
REQ-008 valid  output  1  a holds an undelivered index.
REQ-009 ready  input  1  consumer accepts a when valid && ready.
REQ-010 last  output  1  current a is the final pending index of this capture.
REQ-011 busy  output  1  capture in progress, new load ignored.
REQ-012 none  output  1  one-cycle pulse: capture attempted with y == 0.

Function
REQ-013 The block SHALL implement states IDLE and EMIT; reset state IDLE.
REQ-014 In IDLE with load && e && y != 0, the block SHALL capture pending <= y and enter EMIT; busy = 1 from the next cycle.
REQ-015 In IDLE with load && e && y == 0, the block SHALL stay in IDLE and assert none for exactly one cycle; valid stays 0.
REQ-016 In IDLE with load && !e, or !load, the block SHALL hold all state; none = 0.
REQ-017 Latency: valid SHALL rise the cycle after capture, with a = priority index of pending (per PRIO_HIGH).
REQ-018 a, valid and last SHALL be registered outputs; no combinational path from y, load, e or ready to any output.
REQ-019 Once valid = 1, a and last SHALL remain stable until the cycle of valid && ready.
REQ-020 On valid && ready, the block SHALL clear the delivered bit in pending and present the next priority index on the following cycle, with no bubble.
REQ-021 last SHALL equal 1 exactly when pending has one bit set.
REQ-022 On acceptance with last = 1, the block SHALL return to IDLE: valid = 0, busy = 0, last = 0 on the next cycle; a holds its last value.
REQ-023 A load in EMIT SHALL be ignored and SHALL NOT pulse none.
REQ-024 e deasserting in EMIT SHALL NOT stall or abort emission.
REQ-025 A new load accepted in the same cycle as final acceptance SHALL NOT be captured; capture is possible from the first IDLE cycle.
REQ-026 A capture of y = 4'b1111 SHALL emit exactly four indices, each exactly once: 3,2,1,0 (PRIO_HIGH=1) or 0,1,2,3 (PRIO_HIGH=0).

Reset
REQ-027 While rst = 1 at a clock edge, the block SHALL force state = IDLE, pending = 0, a = 2'b00, valid = 0, last = 0, busy = 0, none = 0.
REQ-028 rst mid-EMIT SHALL discard all pending indices; no index is emitted after reset releases without a new capture.
REQ-029 rst SHALL take priority over load and ready in the same cycle.

Structure
REQ-030 Shared package enc_pkg SHALL hold the state enum (IDLE, EMIT) and constants REQ_W = 4 and IDX_W = 2.
REQ-031 Priority selection SHALL be a combinational sub-module prio_enc4 (inputs: 4-bit vector and priority mode; outputs: 2-bit index and any-set flag), instantiated once.
REQ-032 Expected RTL size: 120-400 lines including the package and sub-module.

Verification
REQ-033 Reset mid-emission: rst during EMIT with y=4'b1010 capture -> next cycle valid=0, busy=0, a=00; no further indices without a new load.
REQ-034 Multi-hot, ready held high, PRIO_HIGH=1: y=4'b1011, load=1, e=1 -> a=3,1,0 on consecutive cycles; last=1 only with a=0; busy falls the cycle after.
REQ-035 Backpressure: y=4'b0110, ready=0 for 5 cycles then 1 -> a=2 stable with valid=1 across the stall; then a=1 with last=1.
REQ-036 Empty and gating: load=1, e=1, y=0 -> none pulses one cycle, valid stays 0; then load=1, e=0, y=4'b0001 -> no capture, busy stays 0.
REQ-037 Ignored reload and PRIO_HIGH=0: capture y=4'b1111, then pulse load with y=4'b0001 during EMIT -> exactly a=0,1,2,3 emitted; none stays 0.

Source files
------------

// File: rtl/enc_pkg.sv
// Shared types and constants for the sequential 4:2 priority encoder.
// Holds the controller state type and a single-bit-set helper.
package enc_pkg;
   localparam int REQ_W = 4;
   localparam int IDX_W = 2;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   // True when exactly one bit of v is set.
   function automatic logic is_single(input logic [REQ_W-1:0] v);
      return (v != '0) && ((v & (v - REQ_W'(1))) == '0);
   endfunction
endpackage

// File: rtl/prio_enc4.sv
// Combinational 4-bit priority encoder.
// prio_high=1 picks the highest set bit, prio_high=0 picks the lowest.
module prio_enc4
   import enc_pkg::*;
(
   input  logic [REQ_W-1:0] vec,
   input  logic             prio_high,
   output logic [IDX_W-1:0] idx,
   output logic             any
);
   always_comb begin
      idx = '0;
      any = |vec;
      // The last match in scan order wins.
      if (prio_high) begin
         for (int i = 0; i < REQ_W; i++) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int i = REQ_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end
   end
endmodule

// File: rtl/enc42_seq.sv
// Captures a multi-hot request vector and emits its set-bit indices one per
// handshake, in priority order, over a valid/ready interface.
module enc42_seq
   import enc_pkg::*;
#(
   parameter bit PRIO_HIGH = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [REQ_W-1:0] y,
   input  logic             e,
   input  logic             load,
   output logic [IDX_W-1:0] a,
   output logic             valid,
   input  logic             ready,
   output logic             last,
   output logic             busy,
   output logic             none
);
   state_t             state_reg;
   logic [REQ_W-1:0]   pending_reg;
   logic [IDX_W-1:0]   a_reg;
   logic               valid_reg;
   logic               last_reg;
   logic               busy_reg;
   logic               none_reg;

   logic [REQ_W-1:0]   a_mask;
   logic [REQ_W-1:0]   remain;
   logic [REQ_W-1:0]   enc_in;
   logic [IDX_W-1:0]   enc_idx;
   logic               enc_any;

   genvar gi;
   generate
      for (gi = 0; gi < REQ_W; gi++) begin : g_mask
         assign a_mask[gi] = (a_reg == IDX_W'(gi));
      end
   endgenerate

   // Pending set once the currently presented index has been delivered.
   assign remain = pending_reg & ~a_mask;
   // One encoder serves both capture (from y) and advance (from remain).
   assign enc_in = (state_reg == IDLE) ? y : remain;

   prio_enc4 u_prio (
      .vec       (enc_in),
      .prio_high (PRIO_HIGH),
      .idx       (enc_idx),
      .any       (enc_any)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= IDLE;
         pending_reg <= '0;
         a_reg       <= '0;
         valid_reg   <= 1'b0;
         last_reg    <= 1'b0;
         busy_reg    <= 1'b0;
         none_reg    <= 1'b0;
      end else begin
         none_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (load && e) begin
                  if (enc_any) begin
                     pending_reg <= y;
                     a_reg       <= enc_idx;
                     valid_reg   <= 1'b1;
                     last_reg    <= is_single(y);
                     busy_reg    <= 1'b1;
                     state_reg   <= EMIT;
                  end else begin
                     none_reg <= 1'b1;
                  end
               end
            end
            EMIT: begin
               if (valid_reg && ready) begin
                  if (last_reg) begin
                     state_reg   <= IDLE;
                     pending_reg <= '0;
                     valid_reg   <= 1'b0;
                     last_reg    <= 1'b0;
                     busy_reg    <= 1'b0;
                  end else begin
                     pending_reg <= remain;
                     a_reg       <= enc_idx;
                     last_reg    <= is_single(remain);
                  end
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign a     = a_reg;
   assign valid = valid_reg;
   assign last  = last_reg;
   assign busy  = busy_reg;
   assign none  = none_reg;
endmodule

// File: tb/tb_enc42_seq.sv
// Scoreboard bench for enc42_seq: both priority modes share one stimulus
// stream; expected index sequences are queued at capture and popped on handshakes.
module tb_enc42_seq;
   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] y = 4'b0000;
   logic       e = 1'b0;
   logic       load = 1'b0;
   logic       ready = 1'b0;

   logic [1:0] a_hi, a_lo;
   logic       valid_hi, valid_lo, last_hi, last_lo;
   logic       busy_hi, busy_lo, none_hi, none_lo;

   int checks = 0;
   int failures = 0;

   logic [2:0] q_hi[$];
   logic [2:0] q_lo[$];

   // Reference model state
   logic busy_m = 1'b0;
   logic none_m = 1'b0;
   logic rst_prev = 1'b0;
   int   rem_m = 0;

   always #5 clk = ~clk;

   enc42_seq #(.PRIO_HIGH(1'b1)) dut_hi (
      .clk(clk), .rst(rst), .y(y), .e(e), .load(load), .a(a_hi),
      .valid(valid_hi), .ready(ready), .last(last_hi), .busy(busy_hi), .none(none_hi)
   );

   enc42_seq #(.PRIO_HIGH(1'b0)) dut_lo (
      .clk(clk), .rst(rst), .y(y), .e(e), .load(load), .a(a_lo),
      .valid(valid_lo), .ready(ready), .last(last_lo), .busy(busy_lo), .none(none_lo)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int popcnt(input logic [3:0] v);
      int n = 0;
      for (int i = 0; i < 4; i++) n += int'(v[i]);
      return n;
   endfunction

   // Push the list of set bits, in each priority order, flagging the final one.
   task automatic push_capture(input logic [3:0] v);
      int total = popcnt(v);
      int k = 0;
      for (int i = 3; i >= 0; i--) begin
         if (v[i]) begin
            k++;
            q_hi.push_back({i[1:0], (k == total)});
         end
      end
      k = 0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) begin
            k++;
            q_lo.push_back({i[1:0], (k == total)});
         end
      end
   endtask

   task automatic model_step();
      chk("busy_hi", int'(busy_hi), int'(busy_m));
      chk("busy_lo", int'(busy_lo), int'(busy_m));
      chk("valid_hi", int'(valid_hi), int'(busy_m));
      chk("valid_lo", int'(valid_lo), int'(busy_m));
      chk("none_hi", int'(none_hi), int'(none_m));
      chk("none_lo", int'(none_lo), int'(none_m));
      if (rst_prev) begin
         chk("rst_a_hi", int'(a_hi), 0);
         chk("rst_last_hi", int'(last_hi), 0);
      end
      if (rst) begin
         q_hi.delete();
         q_lo.delete();
         busy_m = 1'b0;
         none_m = 1'b0;
         rem_m = 0;
         rst_prev = 1'b1;
      end else begin
         rst_prev = 1'b0;
         none_m = !busy_m && load && e && (y == 4'b0000);
         if (busy_m) begin
            if (ready) begin
               rem_m--;
               if (rem_m == 0) busy_m = 1'b0;
            end
         end else if (load && e && (y != 4'b0000)) begin
            push_capture(y);
            busy_m = 1'b1;
            rem_m = popcnt(y);
         end
      end
   endtask

   task automatic cyc(input logic [3:0] yv, input logic ev, input logic ldv,
                      input logic rdv, input logic rsv);
      y = yv; e = ev; load = ldv; ready = rdv; rst = rsv;
      @(negedge clk);
      model_step();
      @(posedge clk);
      #1;
   endtask

   // Monitors: pop and compare on each handshake, and check stall stability.
   logic       pv_hi = 1'b0, pacc_hi = 1'b0, pl_hi = 1'b0;
   logic [1:0] pa_hi = 2'b00;
   always @(negedge clk) begin
      logic [2:0] ex;
      if (pv_hi && !pacc_hi && valid_hi) begin
         chk("stable_a_hi", int'(a_hi), int'(pa_hi));
         chk("stable_last_hi", int'(last_hi), int'(pl_hi));
      end
      if (!rst && valid_hi && ready) begin
         if (q_hi.size() == 0) begin
            chk("extra_hi", 1, 0);
         end else begin
            ex = q_hi.pop_front();
            chk("a_hi", int'(a_hi), int'(ex[2:1]));
            chk("last_hi", int'(last_hi), int'(ex[0]));
            $display("hi: a=%0d last=%0b", a_hi, last_hi);
         end
      end
      pv_hi = valid_hi && !rst;
      pacc_hi = valid_hi && ready;
      pa_hi = a_hi;
      pl_hi = last_hi;
   end

   logic       pv_lo = 1'b0, pacc_lo = 1'b0, pl_lo = 1'b0;
   logic [1:0] pa_lo = 2'b00;
   always @(negedge clk) begin
      logic [2:0] ex;
      if (pv_lo && !pacc_lo && valid_lo) begin
         chk("stable_a_lo", int'(a_lo), int'(pa_lo));
         chk("stable_last_lo", int'(last_lo), int'(pl_lo));
      end
      if (!rst && valid_lo && ready) begin
         if (q_lo.size() == 0) begin
            chk("extra_lo", 1, 0);
         end else begin
            ex = q_lo.pop_front();
            chk("a_lo", int'(a_lo), int'(ex[2:1]));
            chk("last_lo", int'(last_lo), int'(ex[0]));
            $display("lo: a=%0d last=%0b", a_lo, last_lo);
         end
      end
      pv_lo = valid_lo && !rst;
      pacc_lo = valid_lo && ready;
      pa_lo = a_lo;
      pl_lo = last_lo;
   end

   initial begin
      for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b1);
      // Multi-hot with ready held high
      cyc(4'b1011, 1'b1, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      // Backpressure
      cyc(4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      // Empty capture, then gated capture
      cyc(4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      cyc(4'b0001, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      // Full capture with ignored reload
      cyc(4'b1111, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0001, 1'b1, 1'b1, 1'b1, 1'b0);
      cyc(4'b0000, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      // Reset mid-emission
      cyc(4'b1010, 1'b1, 1'b1, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
      cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 4; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      // Randomized traffic
      for (int i = 0; i < 400; i++) begin
         cyc(4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 9) < 7),
             1'($urandom_range(0, 49) == 0));
      end
      for (int i = 0; i < 10; i++) cyc(4'b0000, 1'b0, 1'b0, 1'b1, 1'b0);
      chk("drain_hi", q_hi.size(), 0);
      chk("drain_lo", q_lo.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
